// File: rtl/uart_reg_target.sv
// Register target behind the UART transaction master: decodes uart_* commands,
// serves an ID/status/control register bank and returns one response per command.

module uart_ctrl_reg (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_we,
  input  logic [7:0] i_d,
  output logic [7:0] o_q,
  output logic       o_wr
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_q  <= '0;
      o_wr <= 1'b0;
    end else begin
      o_wr <= i_we;
      if (i_we) o_q <= i_d;
    end
  end
endmodule

module uart_reg_target #(
  parameter int          NREGS       = 8,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [7:0]  ID_VALUE    = 8'hA5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [2:0]           uart_MCmd,
  input  logic [7:0]           uart_MAddr,
  input  logic [7:0]           uart_MData,
  output logic                 uart_SCmdAccept,
  output logic [7:0]           uart_SData,
  output logic [1:0]           uart_SResp,
  input  logic [7:0]           status_in,
  output logic [8*NREGS-1:0]   ctrl_out,
  output logic [NREGS-1:0]     ctrl_wr,
  output logic                 busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic [2:0] cmd;
    logic [7:0] addr;
    logic [7:0] data;
  } req_t;

  localparam logic [1:0] RESP_NULL = 2'd0;
  localparam logic [1:0] RESP_DVA  = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd3;

  state_t                  r_state, w_nxt;
  req_t                    r_req;
  logic [3:0]              r_cnt;
  logic [1:0]              r_sresp;
  logic [7:0]              r_sdata;
  logic [NREGS-1:0]        w_hit, w_we;
  logic [NREGS-1:0][7:0]   w_q;
  logic                    w_rd, w_wr, w_ok;
  logic [7:0]              w_rdata;

  assign w_rd = (r_req.cmd == 3'd2);
  assign w_wr = (r_req.cmd == 3'd1);
  assign w_ok = (w_rd && (r_req.addr == 8'h00 || r_req.addr == 8'h01 || |w_hit)) ||
                (w_wr && |w_hit);

  genvar k;
  generate
    for (k = 0; k < NREGS; k++) begin : g_reg
      assign w_hit[k] = (r_req.addr == 8'(k + 2));
      assign w_we[k]  = (r_state == S_ACCEPT) && w_wr && w_hit[k];
      uart_ctrl_reg u_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .i_we    (w_we[k]),
        .i_d     (r_req.data),
        .o_q     (w_q[k]),
        .o_wr    (ctrl_wr[k])
      );
    end
  endgenerate

  assign ctrl_out = w_q;

  always_comb begin
    w_rdata = '0;
    if (r_req.addr == 8'h00)      w_rdata = ID_VALUE;
    else if (r_req.addr == 8'h01) w_rdata = status_in;
    else
      for (int i = 0; i < NREGS; i++)
        if (w_hit[i]) w_rdata = w_q[i];
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:   if (uart_MCmd != 3'd0) w_nxt = S_ACCEPT;
      S_ACCEPT: w_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
      S_WAIT:   if (r_cnt <= 4'd1) w_nxt = S_RESP;
      S_RESP:   w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_req   <= '0;
      r_cnt   <= '0;
      r_sresp <= RESP_NULL;
      r_sdata <= '0;
    end else begin
      r_state <= w_nxt;
      if (r_state == S_IDLE && uart_MCmd != 3'd0)
        r_req <= {uart_MCmd, uart_MAddr, uart_MData};
      if (r_state == S_ACCEPT)    r_cnt <= 4'(WAIT_CYCLES);
      else if (r_state == S_WAIT) r_cnt <= r_cnt - 4'd1;
      // Response is captured on the edge entering RESP so status_in is sampled there.
      if (w_nxt == S_RESP && r_state != S_RESP) begin
        r_sresp <= w_ok ? RESP_DVA : RESP_ERR;
        r_sdata <= (w_ok && w_rd) ? w_rdata : 8'h00;
      end else begin
        r_sresp <= RESP_NULL;
        r_sdata <= '0;
      end
    end
  end

  assign uart_SCmdAccept = (r_state == S_ACCEPT);
  assign uart_SResp      = r_sresp;
  assign uart_SData      = r_sdata;
  assign busy            = (r_state != S_IDLE);

endmodule

// File: doc/uart_reg_target.md
Name: uart_reg_target

Overview:
- Responder end of the uart_* command/response interface. Sits behind the UART transaction master and serves its commands.
- Decodes uart_MCmd/uart_MAddr/uart_MData and drives uart_SCmdAccept/uart_SData/uart_SResp.
- Owns a small register bank: one ID register, one read-only status register, and NREGS read/write control registers. Control values and write strobes go out to the rest of the prototype.

Parameters:
- NREGS, 8, number of R/W control registers (1..16).
- WAIT_CYCLES, 0, extra cycles inserted between accept and response (0..15).
- ID_VALUE, 8'hA5, constant returned by reading address 0x00.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- uart_MCmd  input  3  command: 0 IDLE, 1 WRITE, 2 READ; any other value is illegal.
- uart_MAddr  input  8  register address.
- uart_MData  input  8  write data.
- uart_SCmdAccept  output  1  command accepted; one-cycle pulse.
- uart_SData  output  8  read data; valid only while uart_SResp is DVA.
- uart_SResp  output  2  response: 0 NULL, 1 DVA, 2 FAIL (unused), 3 ERR.
- status_in  input  8  value returned by reading address 0x01.
- ctrl_out  output  8*NREGS  flattened control registers; register k is at bits [8k+7:8k].
- ctrl_wr  output  NREGS  one-cycle write strobe per control register.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: every output goes to 0, the FSM goes to IDLE, and all control registers go to 0. Reset is asynchronous.
- If reset asserts mid-transaction, the pending command is discarded and no response is issued.
- Address map:
  - 0x00: ID, read-only.
  - 0x01: status_in, read-only.
  - 0x02 .. 0x02+NREGS-1: control registers, R/W.
  - Any other address: unmapped.
- Master rule: the master holds MCmd/MAddr/MData stable until it samples uart_SCmdAccept=1. The target never depends on the master dropping the command earlier.
- FSM states: IDLE, ACCEPT, WAIT, RESP.
- IDLE:
  - When MCmd != 0, latch cmd/addr/data and go to ACCEPT.
  - When MCmd == 0, stay in IDLE.
- ACCEPT:
  - uart_SCmdAccept=1 for exactly this one cycle.
  - A legal write to a control register updates that register at the end of this cycle.
  - The matching ctrl_wr bit pulses high during the following cycle, and ctrl_out shows the new value from that cycle on.
  - Next state: WAIT if WAIT_CYCLES>0, otherwise RESP.
- WAIT:
  - Counter is loaded with WAIT_CYCLES on entry.
  - Stay WAIT_CYCLES cycles total, then go to RESP.
  - Inputs are ignored.
- RESP:
  - uart_SResp is valid for exactly one cycle, then the FSM returns to IDLE.
  - uart_SResp and uart_SData are registered outputs.
- Response codes:
  - READ of a mapped address: DVA, with SData = register value at the RESP cycle (status_in sampled on the cycle entering RESP).
  - WRITE to a control register: DVA, SData=0.
  - WRITE to 0x00/0x01, any access to an unmapped address, or an illegal MCmd (3..7): ERR, SData=0, no register change, no ctrl_wr.
- Exactly one response per accepted command. FAIL is never generated.
- Outside RESP: uart_SResp=NULL and uart_SData=0.
- Timing: command first visible at cycle 0 → accept at cycle 1 → response at cycle 2+WAIT_CYCLES → IDLE at 3+WAIT_CYCLES.
- The earliest next command is sampled at cycle 3+WAIT_CYCLES. Back-to-back throughput is one command per 3+WAIT_CYCLES cycles.
- A command presented during ACCEPT/WAIT/RESP is held by the master. It is sampled only in IDLE.
- Write and read of the same register in consecutive commands: the read returns the newly written value.
- Address compare uses the full 8 bits; there is no aliasing or wrap-around.

Test Plan:
- Reset, then read 0x00 with WAIT_CYCLES=0 → accept at cycle 1, SResp=DVA and SData=8'hA5 at cycle 2; SResp=NULL at cycle 3.
- Write 0x3C to 0x02, then read 0x02 → write gets DVA, ctrl_wr[0] pulses once, ctrl_out[7:0]=0x3C; the read returns DVA/0x3C.
- status_in=0x5A, read 0x01 → DVA/0x5A. Write 0x01 → ERR, no ctrl_wr, no control register changes.
- Read 0x0A with NREGS=8 (unmapped); send MCmd=3 to 0x02 → both return ERR/SData=0, and control register 0x02 is unchanged.
- WAIT_CYCLES=4, read 0x00 → accept at cycle 1, response at cycle 6, busy high for cycles 1..6. A second command held from cycle 2 is accepted at cycle 8.
- Assert reset_n=0 during WAIT after a write to 0x03 was accepted → no response ever appears, ctrl_out is all zero, and the FSM is IDLE after release.
